dmem_line_model: RTL

Line-granular data memory with a fixed, parameterised access latency, sitting directly downstream of the data cache's memory port. It accepts one 256-bit line read or write per request, holds the request internally while a latency counter runs, and signals completion with a single-cycle acknowledge. Read data stays stable after the acknowledge, so the cache can fill its SRAM in the following cycle.

---
 rtl/dmem_line_model.sv | 78 +++++++
 1 files changed

// File: rtl/dmem_line_model.sv
// rtl/dmem_line_model.sv - line-granular data memory with fixed access latency
// One 256-bit line per request; a single-cycle ack after LATENCY cycles.
module dmem_line_model #(
    parameter int LINE_AW = 9,
    parameter int LATENCY = 10
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(LATENCY - 1);

    state_t               state_q;
    state_t               state_d;
    logic [3:0]           cnt;
    logic [LINE_AW-1:0]   line_q;
    logic                 wr_q;
    logic [255:0]         wdata_q;
    logic [255:0]         mem [2**LINE_AW];
    logic                 accept;

    // Byte offset and address bits above the array alias away.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:5+LINE_AW], addr_i[4:0]};

    assign ack_o  = (state_q == ST_WAIT) && (cnt == CNT_LAST);
    assign accept = (state_q == ST_IDLE) && enable_i;
    assign data_o = mem[line_q];

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (enable_i) state_d = ST_WAIT;
            ST_WAIT: if (ack_o)    state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt     <= '0;
            line_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                line_q  <= addr_i[5+LINE_AW-1:5];
                wr_q    <= write_i;
                wdata_q <= data_i;
                cnt     <= '0;
            end else if (state_q == ST_WAIT) begin
                // Clear on the ack edge so cnt never passes LATENCY-1.
                cnt <= ack_o ? 4'd0 : cnt + 4'd1;
            end
        end
    end

    // Array is deliberately not reset; commit happens on the edge closing the ack cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i && ack_o && wr_q) begin
            mem[line_q] <= wdata_q;
        end
    end

endmodule
